// File: rtl/lfsr_checker.sv
// Self-synchronising checker for a Fibonacci LFSR stream: hunts for a seed, verifies
// LOCK_CNT predictions, then free-runs and counts mismatches until LOSS_CNT in a row.
//
// state  | meaning
// HUNT   | no seed yet; waiting for a nonzero sample
// VERIFY | seeded; counting consecutive correct predictions
// LOCKED | free-running prediction; mismatches are counted
module lfsr_checker #(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] TAPS     = 4'b1001,
    parameter int               LOCK_CNT = 4,
    parameter int               LOSS_CNT = 3,
    parameter int               CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic             lockup
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   pred, pred_nxt;
    logic [GOOD_W-1:0]  good_cnt, good_cnt_nxt;
    logic [BAD_W-1:0]   bad_run, bad_run_nxt;
    logic [CNT_W-1:0]   err_count_nxt;
    logic               err_pulse_nxt;
    logic               lockup_nxt;
    logic               sample_zero;
    logic               sample_hit;

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ^(s & TAPS)};
    endfunction

    assign sample_zero = (x == '0);
    assign sample_hit  = (x == pred);

    always_comb begin
        state_nxt     = state;
        pred_nxt      = pred;
        good_cnt_nxt  = good_cnt;
        bad_run_nxt   = bad_run;
        err_count_nxt = err_count;
        err_pulse_nxt = 1'b0;
        lockup_nxt    = 1'b0;

        if (in_valid) begin
            unique case (state)
                HUNT: begin
                    if (sample_zero) begin
                        lockup_nxt = 1'b1;
                    end else begin
                        pred_nxt     = lfsr_next(x);
                        good_cnt_nxt = '0;
                        state_nxt    = VERIFY;
                    end
                end
                VERIFY: begin
                    if (sample_hit) begin
                        pred_nxt = lfsr_next(x);
                        if (good_cnt == GOOD_W'(LOCK_CNT - 1)) begin
                            good_cnt_nxt = '0;
                            bad_run_nxt  = '0;
                            state_nxt    = LOCKED;
                        end else begin
                            good_cnt_nxt = good_cnt + 1'b1;
                        end
                    end else if (!sample_zero) begin
                        pred_nxt     = lfsr_next(x);
                        good_cnt_nxt = '0;
                    end else begin
                        lockup_nxt   = 1'b1;
                        good_cnt_nxt = '0;
                        state_nxt    = HUNT;
                    end
                end
                LOCKED: begin
                    // Never reseeded here, so a corrupted sample cannot poison later predictions.
                    pred_nxt = lfsr_next(pred);
                    if (sample_hit) begin
                        bad_run_nxt = '0;
                    end else begin
                        err_pulse_nxt = 1'b1;
                        if (err_count != {CNT_W{1'b1}}) begin
                            err_count_nxt = err_count + 1'b1;
                        end
                        if (bad_run == BAD_W'(LOSS_CNT - 1)) begin
                            bad_run_nxt = '0;
                            state_nxt   = HUNT;
                        end else begin
                            bad_run_nxt = bad_run + 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = HUNT;
                end
            endcase
        end

        if (clear) begin
            err_count_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= HUNT;
            pred      <= '0;
            good_cnt  <= '0;
            bad_run   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
            lockup    <= 1'b0;
        end else begin
            state     <= state_nxt;
            pred      <= pred_nxt;
            good_cnt  <= good_cnt_nxt;
            bad_run   <= bad_run_nxt;
            locked    <= (state_nxt == LOCKED);
            err_pulse <= err_pulse_nxt;
            err_count <= err_count_nxt;
            lockup    <= lockup_nxt;
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: a behavioural model queues the expected outputs
// for every driven cycle; they are popped and compared one edge later.
module tb_lfsr_checker;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] x;
    logic       clear;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_count;
    logic       lockup;

    lfsr_checker dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .x         (x),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .lockup    (lockup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       l;
        logic       e;
        logic [7:0] c;
        logic       z;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    // model state: 0 hunt, 1 verify, 2 locked
    int         m_st;
    logic [3:0] m_pred;
    int         m_good;
    int         m_bad;
    int         m_cnt;
    logic [3:0] g;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] nx(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[0]};
    endfunction

    task automatic model_reset();
        m_st = 0; m_pred = 4'h0; m_good = 0; m_bad = 0; m_cnt = 0;
    endtask

    task automatic model_step(input logic v, input logic [3:0] xv, input logic clr);
        exp_t e;
        logic hit;
        e.e = 1'b0;
        e.z = 1'b0;
        if (v) begin
            if (m_st == 0) begin
                if (xv == 4'h0) e.z = 1'b1;
                else begin m_pred = nx(xv); m_good = 0; m_st = 1; end
            end else if (m_st == 1) begin
                if (xv == m_pred) begin
                    m_good++;
                    m_pred = nx(xv);
                    if (m_good == 4) begin m_st = 2; m_good = 0; m_bad = 0; end
                end else if (xv != 4'h0) begin
                    m_pred = nx(xv); m_good = 0;
                end else begin
                    e.z = 1'b1; m_st = 0; m_good = 0;
                end
            end else begin
                hit = (xv == m_pred);
                m_pred = nx(m_pred);
                if (hit) m_bad = 0;
                else begin
                    e.e = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                    m_bad++;
                    if (m_bad == 3) begin m_st = 0; m_bad = 0; end
                end
            end
        end
        if (clr) m_cnt = 0;
        e.l = (m_st == 2);
        e.c = m_cnt[7:0];
        sbq.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [3:0] xv, input logic clr);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        x        = xv;
        clear    = clr;
        model_step(v, xv, clr);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("locked", {31'd0, locked}, {31'd0, e.l});
        chk("err_pulse", {31'd0, err_pulse}, {31'd0, e.e});
        chk("err_count", {24'd0, err_count}, {24'd0, e.c});
        chk("lockup", {31'd0, lockup}, {31'd0, e.z});
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; x = 4'h0; clear = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
        chk("rst_err_count", {24'd0, err_count}, 32'd0);
        chk("rst_lockup", {31'd0, lockup}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // lock acquisition over three full periods
        g = 4'h1;
        for (int i = 0; i < 45; i++) begin
            drive(1'b1, g, 1'b0);
            if (i == 3) chk("not_locked_before_E", {31'd0, locked}, 32'd0);
            if (i == 4) chk("locked_after_E", {31'd0, locked}, 32'd1);
            g = nx(g);
        end
        chk("no_errors_45", {24'd0, err_count}, 32'd0);

        // single corrupted sample
        while (g != 4'hD) begin drive(1'b1, g, 1'b0); g = nx(g); end
        drive(1'b1, 4'h0, 1'b0);
        chk("single_err_pulse", {31'd0, err_pulse}, 32'd1);
        chk("single_err_count", {24'd0, err_count}, 32'd1);
        chk("single_locked", {31'd0, locked}, 32'd1);
        g = nx(g);
        drive(1'b1, g, 1'b0);
        chk("after_err_match", {31'd0, err_pulse}, 32'd0);
        g = nx(g);

        // loss of lock: predictions 1,3,7 against a stuck 0x5
        drive(1'b0, 4'h0, 1'b1);
        while (g != 4'h8) begin drive(1'b1, g, 1'b0); g = nx(g); end
        drive(1'b1, g, 1'b0);
        g = nx(g);
        repeat (3) begin drive(1'b1, 4'h5, 1'b0); g = nx(g); end
        chk("loss_err_count", {24'd0, err_count}, 32'd3);
        chk("loss_unlocked", {31'd0, locked}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, g, 1'b0);
            g = nx(g);
            if (i == 3) chk("relock_not_yet", {31'd0, locked}, 32'd0);
            if (i == 4) chk("relock", {31'd0, locked}, 32'd1);
        end

        // gaps: garbage on x while in_valid is low must be ignored
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) begin drive(1'b1, g, 1'b0); g = nx(g); end
            else drive(1'b0, 4'($urandom_range(0, 15)), 1'b0);
        end
        chk("gaps_locked", {31'd0, locked}, 32'd1);

        // async reset mid-run with two counted errors
        drive(1'b0, 4'h0, 1'b1);
        drive(1'b1, 4'h0, 1'b0); g = nx(g);
        drive(1'b1, g, 1'b0);    g = nx(g);
        drive(1'b1, 4'h0, 1'b0); g = nx(g);
        drive(1'b1, g, 1'b0);    g = nx(g);
        chk("pre_reset_count", {24'd0, err_count}, 32'd2);
        chk("pre_reset_locked", {31'd0, locked}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_locked", {31'd0, locked}, 32'd0);
        chk("async_err_count", {24'd0, err_count}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // zero in HUNT, then a clean lock proves HUNT was held
        drive(1'b1, 4'h0, 1'b0);
        chk("hunt_lockup", {31'd0, lockup}, 32'd1);
        g = 4'h1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, g, 1'b0);
            g = nx(g);
            if (i == 0) chk("hunt_lockup_clears", {31'd0, lockup}, 32'd0);
            if (i == 3) chk("hunt_not_locked", {31'd0, locked}, 32'd0);
            if (i == 4) chk("hunt_then_lock", {31'd0, locked}, 32'd1);
        end

        // clear coinciding with a counted error
        drive(1'b1, 4'h0, 1'b0);
        g = nx(g);
        chk("pre_clear_count", {24'd0, err_count}, 32'd1);
        drive(1'b1, g ^ 4'h3, 1'b1);
        g = nx(g);
        chk("clear_wins_count", {24'd0, err_count}, 32'd0);
        chk("clear_err_pulse", {31'd0, err_pulse}, 32'd1);
        drive(1'b1, g, 1'b0);
        chk("clear_still_locked", {31'd0, locked}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
